egg_timer_ctrl: RTL and testbench
=================================

EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59; highest minute value reachable by ButtonMin before wrapping to 0 (legal range 1..99).
REQ-002 SHALL have port CLK100MHZ  input  1; the single clock, all state on its rising edge.
REQ-003 SHALL have port reset  input  1; asynchronous, active-high.
REQ-004 SHALL have port enable  input  1; level; 0 freezes the controller.
REQ-005 SHALL have ports ButtonModify, ButtonStart, ButtonMin, ButtonSec  input  1 each; debounced, synchronous levels.
REQ-006 SHALL have ports softboiled, mediumboiled, hardboiled  input  1 each; preset select levels.
REQ-007 SHALL have port sec_tick  input  1; one-cycle pulse once per real second.
REQ-008 SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each; BCD of the current remaining time.
REQ-009 SHALL have port state  output  3; current FSM state encoding.
REQ-010 SHALL have ports led0, running, done, LED  output  1 each: enable echo, RUN state, DONE state, blink.

Function
REQ-011 SHALL derive per-button/preset press pulses = level AND NOT registered previous level; an action SHALL be visible one edge after the first edge sampling the level high.
REQ-012 SHALL implement states IDLE, SET, RUN, PAUSE, DONE.
REQ-013 IDLE: ButtonModify -> SET; ButtonStart with time != 00:00 -> RUN; ButtonStart with 00:00 ignored.
REQ-014 IDLE: preset pulse loads time: soft 06:00, medium 09:30, hard 14:00; simultaneous presses priority hard > medium > soft; presets ignored in other states.
REQ-015 SET: ButtonMin increments minutes, MAX_MIN wraps to 00; ButtonSec increments seconds, 59 wraps to 00 with no carry; both same cycle apply both.
REQ-016 SET: ButtonModify -> IDLE; ButtonStart with time != 00:00 -> RUN.
REQ-017 On every entry to RUN from IDLE or SET the current time SHALL be copied into a programmed-time register.
REQ-018 RUN: each sec_tick decrements time by one second; ss 00 borrows to 59 and decrements minutes; tick at 00:01 yields 00:00 and -> DONE on the same edge.
REQ-019 RUN: ButtonStart -> PAUSE; PAUSE: ButtonStart -> RUN, ButtonModify -> SET, sec_tick ignored.
REQ-020 DONE: ButtonStart or ButtonModify -> IDLE and reload time from the programmed-time register.
REQ-021 Simultaneous sec_tick and ButtonStart in RUN: button wins, tick dropped, time unchanged.
REQ-022 Simultaneous ButtonStart and ButtonModify: ButtonStart has priority in every state.
REQ-023 enable=0: state, time, programmed register, LED held; pulses and ticks discarded; previous-level registers keep sampling so no pulse fires on re-enable for a held button.
REQ-024 LED SHALL toggle on each sec_tick in RUN and DONE, and be 0 in IDLE, SET, PAUSE.
REQ-025 led0 = enable; running = (state==RUN); done = (state==DONE); all registered or driven from registers only.

Reset
REQ-026 On reset: state IDLE, time 00:00, programmed register 00:00, LED 0, previous-level registers 0; running, done 0.
REQ-027 Reset asserted mid-RUN SHALL abort immediately to the reset values with no DONE pulse.

Structure
REQ-028 A shared package egg_pkg SHALL hold the state enumeration and the three preset BCD constants.
REQ-029 A sub-module bcd_mmss_counter SHALL hold the four BCD digits with load, inc_min, inc_sec, dec and zero-flag controls; the FSM stays in egg_timer_ctrl.

Verification
REQ-030 Reset, softboiled pulse in IDLE -> digits 0,6,0,0; ButtonStart -> RUN; 3 ticks -> 05:57, LED toggled 3 times.
REQ-031 SET, ButtonSec x61 from 00:00 -> 00:01 (no minute carry); ButtonMin x60 with MAX_MIN=59 -> 00:01.
REQ-032 Load 00:02, start, 2 ticks -> 00:00, DONE, done=1; ButtonStart -> IDLE with 00:02 restored.
REQ-033 RUN at 01:00, ButtonStart and sec_tick same cycle -> PAUSE, 01:00; 5 ticks -> still 01:00; ButtonStart, 1 tick -> 00:59.
REQ-034 RUN at 09:30, enable=0 for 4 ticks -> 09:30 held; enable=1, 1 tick -> 09:29; reset mid-RUN -> IDLE, 00:00, done=0.
REQ-035 IDLE at 00:00, ButtonStart -> state stays IDLE; hard+soft same cycle -> 14:00.

Source files
------------

// File: rtl/egg_pkg.sv
// Shared types for the egg timer: FSM state encoding and preset times.
package egg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    localparam mmss_t ZERO_TIME = 16'h0000;
    localparam mmss_t SOFT_TIME = 16'h0600;
    localparam mmss_t MED_TIME  = 16'h0930;
    localparam mmss_t HARD_TIME = 16'h1400;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss register with load, independent minute/second
// increments (no carry between them) and a borrowing one-second decrement.
module bcd_mmss_counter
    import egg_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  mmss_t load_value,
    input  logic  inc_min,
    input  logic  inc_sec,
    input  logic  dec,
    output mmss_t value,
    output logic  zero,
    output logic  one
);

    mmss_t cur;
    mmss_t nxt;
    logic [7:0] min_bin;

    assign value   = cur;
    assign zero    = (cur == ZERO_TIME);
    assign one     = (cur == 16'h0001);
    assign min_bin = 8'(cur.min_tens) * 8'd10 + 8'(cur.min_ones);

    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_value;
        end else if (dec) begin
            if (!zero) begin
                if (cur.sec_ones != 4'd0) begin
                    nxt.sec_ones = cur.sec_ones - 4'd1;
                end else begin
                    nxt.sec_ones = 4'd9;
                    if (cur.sec_tens != 4'd0) begin
                        nxt.sec_tens = cur.sec_tens - 4'd1;
                    end else begin
                        nxt.sec_tens = 4'd5;
                        if (cur.min_ones != 4'd0) begin
                            nxt.min_ones = cur.min_ones - 4'd1;
                        end else begin
                            nxt.min_ones = 4'd9;
                            nxt.min_tens = cur.min_tens - 4'd1;
                        end
                    end
                end
            end
        end else begin
            // Minutes wrap at MAX_MIN; a preset above it also wraps to 0.
            if (inc_min) begin
                if (min_bin >= 8'(MAX_MIN)) begin
                    nxt.min_tens = 4'd0;
                    nxt.min_ones = 4'd0;
                end else if (cur.min_ones == 4'd9) begin
                    nxt.min_ones = 4'd0;
                    nxt.min_tens = cur.min_tens + 4'd1;
                end else begin
                    nxt.min_ones = cur.min_ones + 4'd1;
                end
            end
            if (inc_sec) begin
                if (cur.sec_tens == 4'd5 && cur.sec_ones == 4'd9) begin
                    nxt.sec_tens = 4'd0;
                    nxt.sec_ones = 4'd0;
                end else if (cur.sec_ones == 4'd9) begin
                    nxt.sec_ones = 4'd0;
                    nxt.sec_tens = cur.sec_tens + 4'd1;
                end else begin
                    nxt.sec_ones = cur.sec_ones + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= ZERO_TIME;
        else     cur <= nxt;
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: button edge detection, five-state FSM,
// programmed-time memory and blink LED around a BCD mm:ss counter.
module egg_timer_ctrl
    import egg_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       enable,
    input  logic       ButtonModify,
    input  logic       ButtonStart,
    input  logic       ButtonMin,
    input  logic       ButtonSec,
    input  logic       softboiled,
    input  logic       mediumboiled,
    input  logic       hardboiled,
    input  logic       sec_tick,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       led0,
    output logic       running,
    output logic       done,
    output logic       LED
);

    state_t state_q, state_d;
    mmss_t  cur_time, prog_q, ld_val;
    logic   ld, inc_m, inc_s, dec, save;
    logic   zero, one, led_q, led_d, led0_q;
    logic [6:0] lvl, prev, press;
    logic   p_mod, p_start, p_min, p_sec, p_soft, p_med, p_hard, tick;

    // Previous levels keep sampling while disabled so a held button
    // does not register a press on re-enable.
    assign lvl = {hardboiled, mediumboiled, softboiled,
                  ButtonSec, ButtonMin, ButtonStart, ButtonModify};
    assign press = lvl & ~prev & {7{enable}};
    assign {p_hard, p_med, p_soft, p_sec, p_min, p_start, p_mod} = press;
    assign tick = sec_tick & enable;

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_val  = prog_q;
        inc_m   = 1'b0;
        inc_s   = 1'b0;
        dec     = 1'b0;
        save    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (p_start) begin
                    if (!zero) begin
                        state_d = S_RUN;
                        save    = 1'b1;
                    end
                end else if (p_mod) begin
                    state_d = S_SET;
                end else if (p_hard) begin
                    ld     = 1'b1;
                    ld_val = HARD_TIME;
                end else if (p_med) begin
                    ld     = 1'b1;
                    ld_val = MED_TIME;
                end else if (p_soft) begin
                    ld     = 1'b1;
                    ld_val = SOFT_TIME;
                end
            end
            S_SET: begin
                if (p_start) begin
                    if (!zero) begin
                        state_d = S_RUN;
                        save    = 1'b1;
                    end
                end else if (p_mod) begin
                    state_d = S_IDLE;
                end else begin
                    inc_m = p_min;
                    inc_s = p_sec;
                end
            end
            S_RUN: begin
                if (p_start) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    dec = 1'b1;
                    if (one) state_d = S_DONE;
                end
            end
            S_PAUSE: begin
                if (p_start)    state_d = S_RUN;
                else if (p_mod) state_d = S_SET;
            end
            S_DONE: begin
                if (p_start || p_mod) begin
                    state_d = S_IDLE;
                    ld      = 1'b1;
                    ld_val  = prog_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        led_d = 1'b0;
        if (state_d == S_RUN || state_d == S_DONE) begin
            led_d = led_q ^ (tick &&
                    (state_q == S_RUN || state_q == S_DONE));
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            prog_q  <= ZERO_TIME;
            led_q   <= 1'b0;
            led0_q  <= 1'b0;
            prev    <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            led0_q  <= enable;
            prev    <= lvl;
            if (save) prog_q <= cur_time;
        end
    end

    bcd_mmss_counter #(.MAX_MIN(MAX_MIN)) u_cnt (
        .clk        (CLK100MHZ),
        .rst        (reset),
        .load       (ld),
        .load_value (ld_val),
        .inc_min    (inc_m),
        .inc_sec    (inc_s),
        .dec        (dec),
        .value      (cur_time),
        .zero       (zero),
        .one        (one)
    );

    assign min_tens = cur_time.min_tens;
    assign min_ones = cur_time.min_ones;
    assign sec_tens = cur_time.sec_tens;
    assign sec_ones = cur_time.sec_ones;
    assign state    = state_q;
    assign running  = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign led0     = led0_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed self-checking bench for egg_timer_ctrl with hand-computed
// expected digits, states and LED values.
module tb_egg_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       ButtonModify = 1'b0, ButtonStart = 1'b0;
    logic       ButtonMin = 1'b0, ButtonSec = 1'b0;
    logic       softboiled = 1'b0, mediumboiled = 1'b0, hardboiled = 1'b0;
    logic       sec_tick = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;
    logic       led0, running, done, LED;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] B_MOD = 8'h01, B_START = 8'h02;
    localparam logic [7:0] B_MIN = 8'h04, B_SEC = 8'h08;
    localparam logic [7:0] B_SOFT = 8'h10, B_MED = 8'h20;
    localparam logic [7:0] B_HARD = 8'h40, B_TICK = 8'h80;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_SET = 3'd1, ST_RUN = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3, ST_DONE = 3'd4;

    egg_timer_ctrl #(.MAX_MIN(59)) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .enable       (enable),
        .ButtonModify (ButtonModify),
        .ButtonStart  (ButtonStart),
        .ButtonMin    (ButtonMin),
        .ButtonSec    (ButtonSec),
        .softboiled   (softboiled),
        .mediumboiled (mediumboiled),
        .hardboiled   (hardboiled),
        .sec_tick     (sec_tick),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .state        (state),
        .led0         (led0),
        .running      (running),
        .done         (done),
        .LED          (LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] t_now();
        return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // One cycle with the given inputs high, then one cycle all low.
    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        {sec_tick, hardboiled, mediumboiled, softboiled,
         ButtonSec, ButtonMin, ButtonStart, ButtonModify} = v;
        @(negedge clk);
        {sec_tick, hardboiled, mediumboiled, softboiled,
         ButtonSec, ButtonMin, ButtonStart, ButtonModify} = 8'h00;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_time", t_now(), 32'h0000);
        check("rst_flags", {29'h0, LED, running, done}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("led0_echo", 32'(led0), 32'd1);

        // Soft preset, start, three ticks.
        drive(B_SOFT);
        check("soft_load", t_now(), 32'h0600);
        drive(B_START);
        check("soft_run", 32'(state), 32'(ST_RUN));
        check("running", 32'(running), 32'd1);
        repeat (3) drive(B_TICK);
        check("soft_3tick", t_now(), 32'h0557);
        check("soft_led", 32'(LED), 32'd1);
        drive(B_START);
        check("run_pause", 32'(state), 32'(ST_PAUSE));
        check("pause_led", 32'(LED), 32'd0);
        drive(B_MOD);
        check("pause_set", 32'(state), 32'(ST_SET));

        // Second and minute wrap without carry.
        do_reset();
        drive(B_MOD);
        check("idle_set", 32'(state), 32'(ST_SET));
        repeat (61) drive(B_SEC);
        check("sec_wrap", t_now(), 32'h0001);
        repeat (60) drive(B_MIN);
        check("min_wrap", t_now(), 32'h0001);
        drive(B_MIN | B_SEC);
        check("min_sec_both", t_now(), 32'h0102);
        drive(B_START | B_MOD);
        check("start_over_mod", 32'(state), 32'(ST_RUN));

        // Count to zero, DONE, reload.
        do_reset();
        drive(B_MOD);
        repeat (2) drive(B_SEC);
        drive(B_START);
        drive(B_TICK);
        check("dn_0001", t_now(), 32'h0001);
        drive(B_TICK);
        check("dn_0000", t_now(), 32'h0000);
        check("dn_state", 32'(state), 32'(ST_DONE));
        check("dn_done", 32'(done), 32'd1);
        check("dn_led", 32'(LED), 32'd0);
        drive(B_TICK);
        check("dn_led_blink", 32'(LED), 32'd1);
        check("dn_hold", t_now(), 32'h0000);
        drive(B_START);
        check("dn_idle", 32'(state), 32'(ST_IDLE));
        check("dn_reload", t_now(), 32'h0002);
        check("dn_led_off", 32'(LED), 32'd0);

        // Start and tick together; pause ignores ticks.
        do_reset();
        drive(B_MOD);
        drive(B_MIN);
        drive(B_START);
        drive(B_START | B_TICK);
        check("st_tick_state", 32'(state), 32'(ST_PAUSE));
        check("st_tick_time", t_now(), 32'h0100);
        repeat (5) drive(B_TICK);
        check("pause_ticks", t_now(), 32'h0100);
        drive(B_START);
        check("resume", 32'(state), 32'(ST_RUN));
        drive(B_TICK);
        check("borrow", t_now(), 32'h0059);

        // Enable freeze and held button across re-enable.
        do_reset();
        drive(B_MED);
        check("med_load", t_now(), 32'h0930);
        drive(B_START);
        @(negedge clk);
        enable = 1'b0;
        repeat (4) drive(B_TICK);
        check("dis_hold", t_now(), 32'h0930);
        check("dis_led0", 32'(led0), 32'd0);
        ButtonStart = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("held_btn", 32'(state), 32'(ST_RUN));
        ButtonStart = 1'b0;
        drive(B_TICK);
        check("reen_tick", t_now(), 32'h0929);
        check("reen_led", 32'(LED), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        check("mid_rst_time", t_now(), 32'h0000);
        check("mid_rst_flags", {29'h0, LED, running, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero start ignored; preset priority.
        drive(B_START);
        check("zero_start", 32'(state), 32'(ST_IDLE));
        drive(B_HARD | B_SOFT);
        check("hard_soft", t_now(), 32'h1400);
        drive(B_MED | B_SOFT);
        check("med_soft", t_now(), 32'h0930);
        drive(B_MOD);
        drive(B_SOFT);
        check("preset_in_set", t_now(), 32'h0930);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
